xor_stream_accum_v: RTL
=======================

Name: xor_stream_accum_v

Overview:
Parametrised streaming XOR reducer, the sequential successor to the fixed 4-input XOR gate.
- Accepts WIDTH-bit words over a valid/ready handshake.
- XOR-accumulates them column-wise into a longitudinal redundancy check (LRC) over a frame of up to FRAME_LEN beats.
- Emits the LRC, a parity bit over the LRC, and the beat count.
- Sits between a data source and a checksum/compare stage in the datapath.

Parameters:
WIDTH, 8, data word width in bits (>=1)
FRAME_LEN, 4, maximum beats per frame (>=1); frame closes automatically at this count
ODD_PARITY, 0, 0: o_parity = XOR of o_lrc bits; 1: the inverted value

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  reset
i_valid  in  1  input word valid
i_data  in  WIDTH  input word
i_last  in  1  marks final beat of a frame (qualified by input handshake)
o_ready  out  1  block can accept an input word
o_valid  out  1  frame result valid
o_lrc  out  WIDTH  XOR of all accepted words of the frame
o_parity  out  1  parity over o_lrc per ODD_PARITY
o_count  out  $clog2(FRAME_LEN+1)  number of beats in the frame
i_ready  in  1  downstream accepts result

Behaviour:
- Reset is synchronous and active-high, sampled on the i_clk rising edge.
- Reset values: state=IDLE, accumulator=0, beat counter=0, o_valid=0, o_lrc=0, o_parity=0, o_count=0.
- Reset mid-frame or in DONE discards all partial or pending results; no residue carries into the next frame.
- States:
  - IDLE: no beats accepted.
  - ACCUM: 1..FRAME_LEN-1 beats accepted.
  - DONE: result held.
- o_ready = 1 in IDLE and ACCUM, 0 in DONE. o_ready is a combinational decode of state only, with no dependence on i_valid.
- Input handshake: a beat is accepted when i_valid && o_ready. When not accepted, i_data and i_last are ignored; the source must hold them.
- Beat accepted in IDLE: accumulator <= i_data, counter <= 1, next state ACCUM.
- Beat accepted in ACCUM: accumulator <= accumulator ^ i_data, counter <= counter+1.
- Frame close: an accepted beat with i_last=1, or an accepted beat that makes counter == FRAME_LEN. On close:
  - o_lrc <= final XOR (including this beat).
  - o_count <= final beat count.
  - o_parity <= (^final XOR) ^ ODD_PARITY.
  - o_valid <= 1; next state DONE.
- Latency: o_valid rises the cycle after the closing beat is accepted.
- FRAME_LEN=1, or i_last on the first beat: close from IDLE directly to DONE with count 1.
- DONE:
  - o_valid, o_lrc, o_parity and o_count are held stable until i_ready=1.
  - On the cycle i_ready=1 in DONE: o_valid <= 0, accumulator and counter cleared, next state IDLE.
  - No input beat is accepted in the same cycle (o_ready=0), so there is one bubble per frame.
- i_ready outside DONE has no effect.
- o_lrc, o_parity and o_count keep their last values after o_valid drops; they are meaningful only while o_valid=1.
- Idle gaps (i_valid=0) inside a frame are allowed, for any length; the accumulator holds.
- Arithmetic: pure bitwise XOR, no carries. The counter saturates by construction because the frame closes at FRAME_LEN.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and a count-width helper constant/function (clog2).
- Sub-module xor_tree_v:
  - Purely combinational, parametrised N-input XOR reduction built as a balanced tree of XOR2_gate_v instances.
  - Used for the o_parity reduction over the WIDTH-bit final XOR.
  - Reusable wherever XOR4-style reducers are currently instanced.

Test Plan:
1. WIDTH=8, FRAME_LEN=4, ODD_PARITY=0; reset 2 cycles, then back-to-back 0x01,0x02,0x04,0x08, i_ready=1 -> one cycle after 4th beat: o_valid=1, o_lrc=0x0F, o_parity=0, o_count=4. Next cycle o_valid=0, o_ready=1.
2. Short frame 0xFF, then 0x0F with i_last=1 -> o_lrc=0xF0, o_parity=0, o_count=2.
3. Backpressure: close a frame 0x11,0x22,0x44,0x88 with i_ready=0 for 3 cycles while i_valid=1 with 0x55 -> o_lrc=0xFF held stable, o_ready=0, 0x55 not absorbed. Raise i_ready -> IDLE. Next frame 0x03 with i_last gives o_lrc=0x03, o_count=1.
4. Gapped input: 0xA5, gap, 0x5A, gap 3 cycles, 0xFF, 0x00 -> o_lrc=0x00, o_parity=0. Same stimulus with ODD_PARITY=1 -> o_parity=1.
5. Reset mid-frame after beats 0xF0,0x0F, then frame 0x81 with i_last=1 -> o_lrc=0x81 (not 0x7E), o_parity=0, o_count=1. o_valid=0 during and after the reset cycle.
6. FRAME_LEN=1 instance: beats 0x07 and 0x06 each accepted after the previous result handshake -> results 0x07/parity 1 and 0x06/parity 0, each with o_count=1.

Source files
------------

// File: rtl/xor_stream_accum_v_pkg.sv
// Shared definitions for the streaming XOR/LRC reducer: FSM encodings and
// the helper that sizes the beat counter.
package xor_stream_accum_v_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Counter must hold FRAME_LEN itself, hence n + 1.
    function automatic int count_width(input int n);
        int w;
        w = $clog2(n + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/xor_stream_accum_v_if.sv
// Input stream and result handshake of the XOR/LRC reducer, bundled for
// point-to-point hookup between a source, the reducer and a checker stage.
interface xor_stream_accum_v_if
    import xor_stream_accum_v_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
);

    localparam int CW = count_width(FRAME_LEN);

    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             i_last;
    logic             o_ready;

    logic             o_valid;
    logic [WIDTH-1:0] o_lrc;
    logic             o_parity;
    logic [CW-1:0]    o_count;
    logic             i_ready;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_last,
        output o_ready,
        output o_valid,
        output o_lrc,
        output o_parity,
        output o_count,
        input  i_ready
    );

    modport master (
        output i_valid,
        output i_data,
        output i_last,
        input  o_ready,
        input  o_valid,
        input  o_lrc,
        input  o_parity,
        input  o_count,
        output i_ready
    );

endinterface

// File: rtl/XOR2_gate_v.sv
// Two-input XOR cell; the leaf element of the balanced XOR reduction tree.
module XOR2_gate_v (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_tree_v.sv
// Combinational N-input XOR reduction built as a balanced binary tree of
// XOR2_gate_v cells; drop-in for the older fixed XOR4-style reducers.
module xor_tree_v #(
    parameter int N = 8
) (
    input  logic [N-1:0] bits,
    output logic         result
);

    localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
    localparam int P      = 1 << LEVELS;

    // Level 0 holds the inputs padded to a power of two with zeros, which
    // leave the XOR unchanged; each further level halves the node count.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int W = P >> l;
        logic [W-1:0] v;

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < P; j++) begin : g_bit
                if (j < N) begin : g_real
                    assign v[j] = bits[j];
                end else begin : g_pad
                    assign v[j] = 1'b0;
                end
            end
        end else begin : g_node
            for (genvar j = 0; j < W; j++) begin : g_pair
                XOR2_gate_v u_xor2 (
                    .a (g_lvl[l-1].v[2*j]),
                    .b (g_lvl[l-1].v[2*j+1]),
                    .y (v[j])
                );
            end
        end
    end

    assign result = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/xor_stream_accum_v.sv
// Streaming column-wise XOR reducer: folds up to FRAME_LEN words into an LRC
// and presents LRC, parity and beat count on a valid/ready result port.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | no beats of the current frame accepted yet
// ST_ACCUM | 1..FRAME_LEN-1 beats accepted, frame still open
// ST_DONE  | result held on the output until i_ready
module xor_stream_accum_v
    import xor_stream_accum_v_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FRAME_LEN  = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input logic               i_clk,
    input logic               i_rst,
    xor_stream_accum_v_if.slave bus
);

    localparam int CW = count_width(FRAME_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_LEN);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             valid_q;
    logic [WIDTH-1:0] lrc_q;
    logic             parity_q;
    logic [CW-1:0]    count_q;

    logic             ready;
    logic             accept;
    logic             first_beat;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_next;
    logic             close_frame;
    logic             xor_parity;
    logic             parity_next;

    always_comb begin
        ready = 1'b0;
        case (state_q)
            ST_IDLE:  ready = 1'b1;
            ST_ACCUM: ready = 1'b1;
            default:  ready = 1'b0;
        endcase
    end

    assign accept     = bus.i_valid && ready;
    assign first_beat = (state_q == ST_IDLE);

    // The first beat of a frame loads rather than folds, so no stale
    // accumulator content can leak in even if clearing were ever skipped.
    assign acc_next = first_beat ? bus.i_data : (acc_q ^ bus.i_data);
    assign cnt_next = first_beat ? CW'(1) : (cnt_q + CW'(1));

    assign close_frame = accept && (bus.i_last || (cnt_next == CNT_MAX));

    xor_tree_v #(
        .N (WIDTH)
    ) u_parity_tree (
        .bits   (acc_next),
        .result (xor_parity)
    );

    assign parity_next = xor_parity ^ ODD_PARITY;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            lrc_q    <= '0;
            parity_q <= 1'b0;
            count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_next;
                        if (close_frame) begin
                            lrc_q    <= acc_next;
                            count_q  <= cnt_next;
                            parity_q <= parity_next;
                            valid_q  <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q  <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    // Result fields stay as-is after o_valid drops.
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_valid  = valid_q;
    assign bus.o_lrc    = lrc_q;
    assign bus.o_parity = parity_q;
    assign bus.o_count  = count_q;

endmodule
